// File: rtl/cache_pkg.sv
// Shared definitions for the 2-way set-associative write-through cache:
// field widths, controller states and a line word-select helper.
package cache_pkg;

    localparam int          TAG_W             = 10;
    localparam int          IDX_W             = 6;
    localparam int          LINE_W            = 64;
    localparam int          WORD_W            = 32;
    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;
    localparam int          SETS_DEFAULT      = 64;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_MISS = 2'd1,
        WRITE     = 2'd2
    } state_t;

    function automatic logic [WORD_W-1:0] sel_word(input logic [LINE_W-1:0] line, input logic word_sel);
        return word_sel ? line[2*WORD_W-1:WORD_W] : line[WORD_W-1:0];
    endfunction

endpackage

// File: rtl/cache_way.sv
// One way of the cache: valid bits, tag and line storage per set, with
// combinational lookup and synchronous line fill / single-word update.
module cache_way
    import cache_pkg::*;
#(
    parameter int SETS = SETS_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [TAG_W-1:0]  i_tag,
    input  logic              i_fill_en,
    input  logic [LINE_W-1:0] i_fill_line,
    input  logic              i_word_wr_en,
    input  logic              i_word_sel,
    input  logic [WORD_W-1:0] i_word_data,
    output logic              o_valid,
    output logic              o_hit,
    output logic [LINE_W-1:0] o_line
);

    logic [SETS-1:0]   r_valid;
    logic [TAG_W-1:0]  r_tag  [SETS];
    logic [LINE_W-1:0] r_data [SETS];

    // Only the valid bits need clearing; tag/data stay unreset so they map to RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_fill_en) begin
            r_valid[i_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_fill_en) begin
            r_tag[i_idx]  <= i_tag;
            r_data[i_idx] <= i_fill_line;
        end else if (i_word_wr_en) begin
            r_data[i_idx][32*i_word_sel +: WORD_W] <= i_word_data;
        end
    end

    assign o_valid = r_valid[i_idx];
    assign o_hit   = r_valid[i_idx] && (r_tag[i_idx] == i_tag);
    assign o_line  = r_data[i_idx];

endmodule

// File: rtl/cache_controller.sv
// 2-way set-associative, write-through, no-write-allocate cache controller
// between the MEM stage and a 64-bit-line SRAM with a ready handshake.
module cache_controller
    import cache_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT,
    parameter int          SETS      = SETS_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_rd_en,
    input  logic              mem_wr_en,
    input  logic [31:0]       address,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ready,
    output logic              sram_rd_en,
    output logic              sram_wr_en,
    output logic [31:0]       sram_address,
    output logic [31:0]       sram_wdata,
    input  logic [LINE_W-1:0] sram_rdata,
    input  logic              sram_ready
);

    state_t            r_state;
    state_t            w_state_next;
    logic [SETS-1:0]   r_lru;

    logic [31:0]       w_adr;
    logic              w_word;
    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic              w_unused_adr_bits;

    logic [1:0]        w_valid;
    logic [1:0]        w_hit;
    logic [LINE_W-1:0] w_line [2];
    logic              w_hit_way;
    logic              w_victim;
    logic              w_fill_en;
    logic              w_word_wr_en;
    logic              w_lru_wr;
    logic              w_lru_val;

    assign w_adr             = address - BASE_ADDR;
    assign w_word            = w_adr[2];
    assign w_idx             = w_adr[8:3];
    assign w_tag             = w_adr[18:9];
    assign w_unused_adr_bits = ^{w_adr[31:19], w_adr[1:0]};

    assign w_hit_way = w_hit[1];
    // Fill an invalid way first (way0 preferred), otherwise the least-recent one.
    assign w_victim  = !w_valid[0] ? 1'b0 : (!w_valid[1] ? 1'b1 : r_lru[w_idx]);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_way
            cache_way #(.SETS(SETS)) u_way (
                .clk          (clk),
                .rst          (rst),
                .i_idx        (w_idx),
                .i_tag        (w_tag),
                .i_fill_en    (w_fill_en && (w_victim == 1'(gi))),
                .i_fill_line  (sram_rdata),
                .i_word_wr_en (w_word_wr_en && w_hit[gi]),
                .i_word_sel   (w_word),
                .i_word_data  (wdata),
                .o_valid      (w_valid[gi]),
                .o_hit        (w_hit[gi]),
                .o_line       (w_line[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_lru   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_lru_wr) begin
                r_lru[w_idx] <= w_lru_val;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        ready        = 1'b1;
        rdata        = '0;
        sram_rd_en   = 1'b0;
        sram_wr_en   = 1'b0;
        sram_address = '0;
        sram_wdata   = '0;
        w_fill_en    = 1'b0;
        w_word_wr_en = 1'b0;
        w_lru_wr     = 1'b0;
        w_lru_val    = 1'b0;
        if (!rst) begin
            case (r_state)
                IDLE: begin
                    if (mem_rd_en) begin
                        if (|w_hit) begin
                            rdata     = sel_word(w_line[w_hit_way], w_word);
                            w_lru_wr  = 1'b1;
                            w_lru_val = ~w_hit_way;
                        end else begin
                            ready        = 1'b0;
                            sram_rd_en   = 1'b1;
                            sram_address = address;
                            w_state_next = READ_MISS;
                        end
                    end else if (mem_wr_en) begin
                        ready        = 1'b0;
                        sram_wr_en   = 1'b1;
                        sram_address = address;
                        sram_wdata   = wdata;
                        w_state_next = WRITE;
                        if (|w_hit) begin
                            w_word_wr_en = 1'b1;
                            w_lru_wr     = 1'b1;
                            w_lru_val    = ~w_hit_way;
                        end
                    end
                end
                READ_MISS: begin
                    ready        = 1'b0;
                    sram_rd_en   = 1'b1;
                    sram_address = address;
                    if (sram_ready) begin
                        rdata        = sel_word(sram_rdata, w_word);
                        ready        = 1'b1;
                        w_fill_en    = 1'b1;
                        w_lru_wr     = 1'b1;
                        w_lru_val    = ~w_victim;
                        w_state_next = IDLE;
                    end
                end
                WRITE: begin
                    ready        = 1'b0;
                    sram_wr_en   = 1'b1;
                    sram_address = address;
                    sram_wdata   = wdata;
                    if (sram_ready) begin
                        ready        = 1'b1;
                        w_state_next = IDLE;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// Directed plus randomized check of cache_controller against a transaction-level
// cache model and an SRAM that answers 5 cycles after each request starts.
module tb_cache_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_rd_en, mem_wr_en;
    logic [31:0] address, wdata, rdata;
    logic        ready;
    logic        sram_rd_en, sram_wr_en;
    logic [31:0] sram_address, sram_wdata;
    logic [63:0] sram_rdata;
    logic        sram_ready;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cache_controller #(.BASE_ADDR(32'd1024), .SETS(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_rd_en    (mem_rd_en),
        .mem_wr_en    (mem_wr_en),
        .address      (address),
        .wdata        (wdata),
        .rdata        (rdata),
        .ready        (ready),
        .sram_rd_en   (sram_rd_en),
        .sram_wr_en   (sram_wr_en),
        .sram_address (sram_address),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata),
        .sram_ready   (sram_ready)
    );

    function automatic logic [31:0] hash(input logic [9:0] i);
        return ({22'd0, i} * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    // SRAM model: word memory over a 4 KB window above the base address
    logic [31:0]   smem [1024];
    logic [1023:0] s_wr = '0;
    int            s_cnt;
    logic [31:0]   s_adr;
    logic [9:0]    s_lo, s_hi;

    assign s_adr      = sram_address - 32'd1024;
    assign s_lo       = {s_adr[11:3], 1'b0};
    assign s_hi       = {s_adr[11:3], 1'b1};
    assign sram_ready = (s_cnt == 5);
    assign sram_rdata = {(s_wr[s_hi] ? smem[s_hi] : hash(s_hi)),
                         (s_wr[s_lo] ? smem[s_lo] : hash(s_lo))};

    always @(posedge clk) begin
        if (rst) begin
            s_cnt <= 0;
        end else if (sram_rd_en || sram_wr_en) begin
            if (sram_ready) begin
                s_cnt <= 0;
                if (sram_wr_en) begin
                    smem[s_adr[11:2]] <= sram_wdata;
                    s_wr[s_adr[11:2]] <= 1'b1;
                end
            end else begin
                s_cnt <= s_cnt + 1;
            end
        end else begin
            s_cnt <= 0;
        end
    end

    // Reference model: golden memory plus a 2-way cache with per-set LRU
    logic [31:0]   gmem [1024];
    logic [1023:0] g_wr = '0;
    bit            m_valid [2][64];
    bit   [9:0]    m_tag   [2][64];
    bit   [31:0]   m_data  [2][64][2];
    bit            m_lru   [64];

    function automatic logic [31:0] gword(input logic [9:0] i);
        return g_wr[i] ? gmem[i] : hash(i);
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 64; s++) begin
            m_valid[0][s] = 0;
            m_valid[1][s] = 0;
            m_lru[s]      = 0;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_check(input string tag, input bit full);
        @(negedge clk);
        check({tag, ".ready"}, ready, 1);
        check({tag, ".rdata"}, rdata, 0);
        check({tag, ".sram_rd_en"}, sram_rd_en, 0);
        check({tag, ".sram_wr_en"}, sram_wr_en, 0);
        if (full) begin
            check({tag, ".sram_address"}, sram_address, 0);
            check({tag, ".sram_wdata"}, sram_wdata, 0);
        end
        @(posedge clk);
        #1;
    endtask

    // One MEM-stage request, held until ready; called at posedge+1
    task automatic transact(input string tag, input bit is_wr, input bit both,
                            input logic [31:0] addr, input logic [31:0] data,
                            output int cycles, output logic [31:0] rd_obs);
        logic [31:0] adr;
        int          idx, w, hit, exp_cyc, victim;
        logic [9:0]  tg, gi;
        logic [31:0] exp_rd;
        bit          exp_rd_en, got;
        adr = addr - 32'd1024;
        idx = int'(adr[8:3]);
        w   = int'(adr[2]);
        tg  = adr[18:9];
        gi  = adr[11:2];
        hit = -1;
        for (int k = 1; k >= 0; k--)
            if (m_valid[k][idx] && m_tag[k][idx] == tg) hit = k;
        if (is_wr) begin
            exp_cyc = 6; exp_rd = 0; exp_rd_en = 0;
        end else if (hit >= 0) begin
            exp_cyc = 1; exp_rd = m_data[hit][idx][w]; exp_rd_en = 0;
        end else begin
            exp_cyc = 6; exp_rd = gword(gi); exp_rd_en = 1;
        end

        mem_rd_en = !is_wr || both;
        mem_wr_en = is_wr || both;
        address   = addr;
        wdata     = data;
        cycles    = 0;
        got       = 0;
        rd_obs    = 'x;
        while (!got && cycles < 20) begin
            @(negedge clk);
            cycles++;
            check({tag, ".sram_rd_en"}, sram_rd_en, exp_rd_en);
            check({tag, ".sram_wr_en"}, sram_wr_en, is_wr);
            if (exp_rd_en || is_wr) check({tag, ".sram_address"}, sram_address, addr);
            if (is_wr) check({tag, ".sram_wdata"}, sram_wdata, data);
            if (ready) begin
                got    = 1;
                rd_obs = rdata;
                check({tag, ".rdata"}, rdata, exp_rd);
            end
            @(posedge clk);
            #1;
        end
        check({tag, ".latency"}, cycles, exp_cyc);
        mem_rd_en = 0;
        mem_wr_en = 0;

        if (is_wr) begin
            gmem[gi] = data;
            g_wr[gi] = 1'b1;
            if (hit >= 0) begin
                m_data[hit][idx][w] = data;
                m_lru[idx] = (hit == 0);
            end
        end else if (hit >= 0) begin
            m_lru[idx] = (hit == 0);
        end else begin
            victim = !m_valid[0][idx] ? 0 : (!m_valid[1][idx] ? 1 : int'(m_lru[idx]));
            m_valid[victim][idx]   = 1;
            m_tag[victim][idx]     = tg;
            m_data[victim][idx][0] = gword({gi[9:1], 1'b0});
            m_data[victim][idx][1] = gword({gi[9:1], 1'b1});
            m_lru[idx] = (victim == 0);
        end
    endtask

    initial begin
        int          cyc;
        logic [31:0] rd;
        logic [31:0] a;
        int          op;

        rst = 1; mem_rd_en = 0; mem_wr_en = 0; address = 0; wdata = 0;
        model_reset();
        @(posedge clk); #1;
        idle_check("in_reset", 1);
        rst = 0;
        idle_check("after_reset", 1);

        transact("cold_400", 0, 0, 32'h400, 0, cyc, rd);
        check("cold_400.cycles", cyc, 6);
        transact("hit_404", 0, 0, 32'h404, 0, cyc, rd);
        check("hit_404.cycles", cyc, 1);
        transact("hit_400", 0, 0, 32'h400, 0, cyc, rd);
        transact("miss_600", 0, 0, 32'h600, 0, cyc, rd);
        transact("miss_800", 0, 0, 32'h800, 0, cyc, rd);
        check("miss_800.cycles", cyc, 6);
        transact("evicted_400", 0, 0, 32'h400, 0, cyc, rd);
        check("evicted_400.cycles", cyc, 6);

        transact("wr_hit_400", 1, 0, 32'h400, 32'hDEAD_BEEF, cyc, rd);
        transact("rd_after_wr", 0, 0, 32'h400, 0, cyc, rd);
        check("rd_after_wr.cycles", cyc, 1);
        check("rd_after_wr.value", rd, 32'hDEAD_BEEF);
        transact("wr_miss_A00", 1, 0, 32'hA00, 32'h1234_5678, cyc, rd);
        transact("still_800", 0, 0, 32'h800, 0, cyc, rd);
        check("still_800.cycles", cyc, 1);
        transact("no_alloc_A00", 0, 0, 32'hA00, 0, cyc, rd);
        check("no_alloc_A00.cycles", cyc, 6);
        check("no_alloc_A00.value", rd, 32'h1234_5678);

        transact("both_en_408", 0, 1, 32'h408, 32'hFFFF_FFFF, cyc, rd);
        check("both_en_408.cycles", cyc, 6);

        // Reset two cycles into a read miss must abort without filling
        mem_rd_en = 1; address = 32'h410;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1; mem_rd_en = 0;
        idle_check("mid_miss_rst", 1);
        rst = 0;
        model_reset();
        idle_check("post_abort", 1);
        transact("reread_410", 0, 0, 32'h410, 0, cyc, rd);
        check("reread_410.cycles", cyc, 6);
        transact("cleared_400", 0, 0, 32'h400, 0, cyc, rd);
        check("cleared_400.cycles", cyc, 6);

        for (int t = 0; t < 200; t++) begin
            a  = 32'd1024 + ($urandom_range(0, 3) << 9) + ($urandom_range(0, 3) << 3)
               + ($urandom_range(0, 1) << 2) + $urandom_range(0, 3);
            op = $urandom_range(0, 3);
            transact($sformatf("rnd%0d", t), op == 2, op == 3, a, $urandom, cyc, rd);
            if ($urandom_range(0, 4) == 0) idle_check($sformatf("rnd%0d.idle", t), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk input 1 (rising edge, only clock); rst input 1 (synchronous, active-high).
REQ-002 SHALL have parameter BASE_ADDR, default 1024, byte offset subtracted from every request address.
REQ-003 SHALL have parameter SETS, default 64, number of sets per way.
REQ-004 SHALL have MEM-stage ports: mem_rd_en in 1 load request; mem_wr_en in 1 store request; address in 32 byte address; wdata in 32 store data; rdata out 32 load data; ready out 1 request complete / no stall.
REQ-005 SHALL have SRAM-side ports: sram_rd_en out 1; sram_wr_en out 1; sram_address out 32; sram_wdata out 32; sram_rdata in 64 line data; sram_ready in 1 (low while SRAM busy).

Function
REQ-006 SHALL be a 2-way set-associative, write-through, no-write-allocate cache; line = 64 bits (two words).
REQ-007 SHALL decode adr = address - BASE_ADDR: adr[2] word select, adr[8:3] index, adr[18:9] 10-bit tag; adr[1:0] ignored.
REQ-008 SHALL keep per set: valid+tag+64-bit data per way, one LRU bit (0 = way0 least recent).
REQ-009 SHALL use FSM states IDLE, READ_MISS, WRITE; reset state IDLE.
REQ-010 SHALL treat simultaneous mem_rd_en and mem_wr_en as a read.
REQ-011 Read hit in IDLE: rdata = selected word of hit way, ready = 1 same cycle (combinational), LRU points to other way at edge, no SRAM access.
REQ-012 Read miss in IDLE: ready = 0, sram_rd_en = 1, sram_address = address, next state READ_MISS.
REQ-013 In READ_MISS: hold sram_rd_en = 1; while sram_ready = 0 keep ready = 0; when sram_ready = 1 drive rdata = selected word of sram_rdata, ready = 1, write line/tag/valid into LRU way, flip LRU to other way, return IDLE.
REQ-014 Victim when both ways invalid SHALL be way0; when one invalid, the invalid way.
REQ-015 Write in IDLE: ready = 0, sram_wr_en = 1, sram_address = address, sram_wdata = wdata, next state WRITE; on hit update selected word of hit way and mark it most recent; on miss no cache change.
REQ-016 In WRITE: hold sram_wr_en/address/wdata; ready = 1 and return IDLE in cycle sram_ready = 1.
REQ-017 Requester SHALL hold address/wdata/enables stable until ready = 1; controller latches nothing else.
REQ-018 No request: ready = 1, rdata = 0, sram_rd_en = sram_wr_en = 0.
REQ-019 Read of line filled by a preceding miss SHALL hit on next request (back-to-back, no bubble).
REQ-020 sram_rd_en and sram_wr_en SHALL never be high together.

Reset
REQ-021 rst SHALL clear all valid and LRU bits, force IDLE, regardless of state (mid-miss or mid-write aborts; no line fill).
REQ-022 During and after reset (no request): ready = 1, rdata = 0, sram_rd_en = 0, sram_wr_en = 0, sram_address = 0, sram_wdata = 0.

Structure
REQ-023 Shared package cache_pkg SHALL hold state enum, TAG_W = 10, IDX_W = 6, LINE_W = 64, BASE_ADDR default.
REQ-024 Sub-module cache_way (valid/tag/data array of SETS entries, sync write, async read, hit compare) SHALL be instantiated twice.
REQ-025 FSM, LRU array and SRAM-side muxing SHALL live in cache_controller.

Verification (SRAM model: sram_ready low 5 cycles after request)
REQ-026 Cold read address 0x400 -> sram_rd_en for 6 cycles, ready = 1 with rdata = sram_rdata[31:0] on final cycle; way0 set 0 valid.
REQ-027 Read 0x404 right after -> hit, ready = 1 same cycle, rdata = sram_rdata[63:32] of earlier fill, no SRAM access.
REQ-028 Reads 0x400, 0x600, 0x800 (same set 0, tags 0/1/2) -> third evicts tag 0; re-read 0x400 misses.
REQ-029 Write 0xDEADBEEF to cached 0x400 -> sram_wr_en 6 cycles with sram_wdata = 0xDEADBEEF; later read 0x400 hits returning 0xDEADBEEF; write to uncached 0xA00 leaves cache unchanged.
REQ-030 rst asserted 2 cycles into a read miss -> next cycle IDLE, ready = 1, sram_rd_en = 0; re-read same address misses.
REQ-031 mem_rd_en and mem_wr_en both high -> read behaviour only, sram_wr_en stays 0.
